// File: rtl/jk_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter_if
// Purpose : command/grant bundle between the control agents and the shared
//           JK flip-flop bank arbiter.
// Signals :
//   req_i    [NUM_REQ]        per-requester command valid, held until granted
//   idx_i    [NUM_REQ*IDX_W]  per-requester target FF index (slice r = req r)
//   j_i/k_i  [NUM_REQ]        per-requester J and K
//   freeze_i                  stop granting, drain, then hold the bank
//   gnt_o    [NUM_REQ]        one-hot combinational grant
//   frozen_o                  bank is halted
//   q_o      [NUM_FF]         bank state
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface jk_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*IDX_W-1:0] idx_i;
  logic [NUM_REQ-1:0]       j_i;
  logic [NUM_REQ-1:0]       k_i;
  logic                     freeze_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     frozen_o;
  logic [NUM_FF-1:0]        q_o;

  modport master (
    output req_i, idx_i, j_i, k_i, freeze_i,
    input  gnt_o, frozen_o, q_o
  );

  modport slave (
    input  req_i, idx_i, j_i, k_i, freeze_i,
    output gnt_o, frozen_o, q_o
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
// Purpose : shares one bank of NUM_FF JK flip-flops between NUM_REQ
//           requesters. A round-robin arbiter grants one command per cycle;
//           the granted command is registered in a stage register and applied
//           to the bank on the following edge. freeze_i drains the stage and
//           then halts the bank.
// Ports   :
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          jk_bank_arbiter_if.slave (requests, grant, frozen, q)
//   grant_cnt_o  saturating count of accepted commands
//                (present only when JK_ARB_STATS_EN is defined)
// Build option: define JK_ARB_STATS_EN to add the accept counter.
//
// State table
//   state  | meaning
//   RUN    | arbitration active, one grant per cycle
//   DRAIN  | no grants, stage register applies any pending command
//   FROZEN | no grants, bank holds until freeze_i drops
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  jk_bank_arbiter_if.slave   bus
`ifdef JK_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win;
  logic               win_vld;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  logic               stg_vld_q;
  logic [IDX_W-1:0]   stg_idx_q;
  logic               stg_j_q;
  logic               stg_k_q;

  logic [NUM_FF-1:0]  q_q;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (bus.freeze_i) state_d = ST_DRAIN;
      // a freeze pulse that is already gone by the end of DRAIN goes
      // straight back to RUN
      ST_DRAIN:  state_d = bus.freeze_i ? ST_FROZEN : ST_RUN;
      ST_FROZEN: if (!bus.freeze_i) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // ---------------- round-robin search ----------------
  // Scan from the pointer upward, wrapping; the first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && bus.req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win     = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Grant is forced low during reset even though the FSM already sits in RUN.
  always_comb begin
    gnt = '0;
    if (rst_n && (state_q == ST_RUN) && win_vld) gnt = NUM_REQ'(1) << win;
  end

  // a grant is only ever issued to an asserted request
  assign accept = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // ---------------- stage register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q <= 1'b0;
      stg_idx_q <= '0;
      stg_j_q   <= 1'b0;
      stg_k_q   <= 1'b0;
    end else begin
      stg_vld_q <= accept;
      if (accept) begin
        stg_idx_q <= bus.idx_i[int'(win)*IDX_W +: IDX_W];
        stg_j_q   <= bus.j_i[win];
        stg_k_q   <= bus.k_i[win];
      end
    end
  end

  // ---------------- JK bank ----------------
  // Per-FF index decode: an index at or beyond NUM_FF matches no flop and is
  // silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      for (int f = 0; f < NUM_FF; f++) begin
        if (stg_vld_q && (stg_idx_q == IDX_W'(f))) begin
          unique case ({stg_j_q, stg_k_q})
            2'b01:   q_q[f] <= 1'b0;
            2'b10:   q_q[f] <= 1'b1;
            2'b11:   q_q[f] <= ~q_q[f];
            default: q_q[f] <= q_q[f];
          endcase
        end
      end
    end
  end

`ifdef JK_ARB_STATS_EN
  logic [15:0] stat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= '0;
    end else if (accept && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_q <= stat_cnt_q + 16'd1;
    end
  end

  assign grant_cnt_o = stat_cnt_q;
`endif

  assign bus.gnt_o    = gnt;
  assign bus.frozen_o = (state_q == ST_FROZEN);
  assign bus.q_o      = q_q;

endmodule
